// File: rtl/motor_ramp_sequencer.sv
// Duty-cycle slew sequencer between the IR command controller and the motor PWM.
// Ramps toward a latched target, brakes and holds a dead time before a reversal.
module motor_ramp_sequencer #(
   parameter int unsigned clk_hz     = 25_000_000,
   parameter int unsigned ramp_hz    = 1000,
   parameter int unsigned ramp_step  = 4,
   parameter int unsigned dead_ticks = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tgt_valid,
   output logic       tgt_ready,
   input  logic [7:0] tgt_dc,
   input  logic       tgt_dir,
   input  logic       estop,
   output logic [7:0] motor_dc,
   output logic       direction,
   output logic       busy,
   output logic       at_target
);

   localparam int unsigned tick_div  = clk_hz / ramp_hz;
   localparam int unsigned pre_w     = (tick_div > 1) ? $clog2(tick_div) : 1;
   localparam int unsigned dead_w    = (dead_ticks > 1) ? $clog2(dead_ticks + 1) : 1;
   localparam logic [pre_w-1:0]  pre_top   = pre_w'(tick_div - 1);
   localparam logic [dead_w-1:0] dead_last = dead_w'(dead_ticks - 1);
   localparam logic [8:0]        step9     = 9'(ramp_step);
   localparam logic [7:0]        step8     = 8'(ramp_step);

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      RAMP  = 2'd1,
      BRAKE = 2'd2,
      DEAD  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [pre_w-1:0]  pre_cnt;
   logic [dead_w-1:0] dead_cnt, dead_d;
   logic [7:0]        tgt_dc_q;
   logic              tgt_dir_q;
   logic [7:0]        dc_d;
   logic              dir_d;
   logic              tick;
   logic              accept;
   logic              stop_now;
   logic [8:0]        diff9;
   logic [7:0]        ramp_dc;
   logic [7:0]        brake_dc;

   // Free-running ramp prescaler, independent of the sequencer state.
   // NOTE: sequential state is updated only with non-blocking assignments so every
   // register samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (pre_cnt == pre_top) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick      = (pre_cnt == pre_top);
   assign tgt_ready = (state_q == HOLD) || (state_q == RAMP);
   assign accept    = tgt_valid && tgt_ready;
   assign stop_now  = estop && direction;
   assign busy      = (state_q != HOLD);
   assign at_target = (state_q == HOLD) && (motor_dc == tgt_dc_q) && (direction == tgt_dir_q);

   // Distance to target in 9 bits; a step that would overshoot loads the target exactly.
   always_comb begin
      if (tgt_dc_q >= motor_dc) begin
         diff9 = {1'b0, tgt_dc_q} - {1'b0, motor_dc};
      end else begin
         diff9 = {1'b0, motor_dc} - {1'b0, tgt_dc_q};
      end
      if (diff9 <= step9) begin
         ramp_dc = tgt_dc_q;
      end else if (tgt_dc_q > motor_dc) begin
         ramp_dc = motor_dc + step8;
      end else begin
         ramp_dc = motor_dc - step8;
      end
      brake_dc = ({1'b0, motor_dc} <= step9) ? 8'd0 : motor_dc - step8;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      dc_d    = motor_dc;
      dir_d   = direction;
      dead_d  = dead_cnt;
      unique case (state_q)
         HOLD: begin
            if (tgt_dir_q != direction) begin
               if (motor_dc == 8'd0) begin
                  state_d = DEAD;
                  dead_d  = '0;
               end else begin
                  state_d = BRAKE;
               end
            end else if (tgt_dc_q != motor_dc) begin
               state_d = RAMP;
            end
         end
         RAMP: begin
            if (tgt_dir_q != direction) begin
               state_d = BRAKE;
            end else if (motor_dc == tgt_dc_q) begin
               state_d = HOLD;
            end else if (tick) begin
               dc_d = ramp_dc;
            end
         end
         BRAKE: begin
            if (motor_dc == 8'd0) begin
               state_d = DEAD;
               dead_d  = '0;
            end else if (tick) begin
               dc_d = brake_dc;
            end
         end
         DEAD: begin
            if (tick) begin
               if (dead_cnt == dead_last) begin
                  dir_d   = tgt_dir_q;
                  dead_d  = '0;
                  state_d = (tgt_dc_q == 8'd0) ? HOLD : RAMP;
               end else begin
                  dead_d = dead_cnt + 1'b1;
               end
            end
         end
         default: state_d = HOLD;
      endcase
      // Obstruction ahead wins over everything while moving forward.
      if (stop_now) begin
         state_d = HOLD;
         dc_d    = 8'd0;
         dir_d   = direction;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HOLD;
         motor_dc  <= 8'd0;
         direction <= 1'b1;
         dead_cnt  <= '0;
      end else begin
         state_q   <= state_d;
         motor_dc  <= dc_d;
         direction <= dir_d;
         dead_cnt  <= dead_d;
      end
   end

   // A target offered during an estop is handshaken but discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_dc_q  <= 8'd0;
         tgt_dir_q <= 1'b1;
      end else if (stop_now) begin
         tgt_dc_q  <= 8'd0;
      end else if (accept) begin
         tgt_dc_q  <= tgt_dc;
         tgt_dir_q <= tgt_dir;
      end
   end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Scoreboard bench for motor_ramp_sequencer: expected duty/direction changes are
// queued by the stimulus and compared by a monitor whenever the outputs change.
module tb_motor_ramp_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [7:0] tgt_dc;
   logic       tgt_dir;
   logic       estop;
   logic [7:0] motor_dc;
   logic       direction;
   logic       busy;
   logic       at_target;

   typedef struct packed {
      logic [7:0] dc;
      logic       dir;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   motor_ramp_sequencer #(
      .clk_hz    (1000),
      .ramp_hz   (100),
      .ramp_step (32),
      .dead_ticks(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tgt_valid(tgt_valid),
      .tgt_ready(tgt_ready),
      .tgt_dc   (tgt_dc),
      .tgt_dir  (tgt_dir),
      .estop    (estop),
      .motor_dc (motor_dc),
      .direction(direction),
      .busy     (busy),
      .at_target(at_target)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic push(input logic [7:0] dc, input logic dir);
      sb_q.push_back('{dc: dc, dir: dir});
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_dc"}, motor_dc, 0);
      check({name, "_dir"}, direction, 1);
      check({name, "_ready"}, tgt_ready, 1);
      check({name, "_busy"}, busy, 0);
      check({name, "_at_target"}, at_target, 1);
   endtask

   // Called on a falling edge; holds the offer until the DUT shows ready.
   task automatic send(input logic [7:0] dc, input logic dir, output int waited, output logic dir_seen);
      tgt_valid = 1'b1;
      tgt_dc    = dc;
      tgt_dir   = dir;
      waited    = 0;
      while (!tgt_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      dir_seen = direction;
      check("handshake", tgt_ready, 1);
      @(negedge clk);
      tgt_valid = 1'b0;
   endtask

   task automatic wait_dc(input logic [7:0] value, input string name);
      int c = 0;
      while (motor_dc !== value && c < 400) begin
         @(negedge clk);
         c++;
      end
      check(name, motor_dc, value);
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      while ((sb_q.size() != 0 || busy) && c < 600) begin
         @(negedge clk);
         c++;
      end
      check(name, (sb_q.size() == 0 && !busy), 1);
   endtask

   // Monitor: any change on motor_dc/direction must match the next queued value.
   initial begin
      logic [7:0] prev_dc  = 8'd0;
      logic       prev_dir = 1'b1;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (motor_dc !== prev_dc || direction !== prev_dir) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_change: got dc=%0d dir=%0d, expected no change", motor_dc, direction);
            end else begin
               e = sb_q.pop_front();
               check("sb_dc", motor_dc, e.dc);
               check("sb_dir", direction, e.dir);
            end
            prev_dc  = motor_dc;
            prev_dir = direction;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1);
   end

   initial begin
      int   w;
      int   cnt;
      logic d;
      rst_n     = 1'b1;
      tgt_valid = 1'b0;
      tgt_dc    = 8'd0;
      tgt_dir   = 1'b1;
      estop     = 1'b0;
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset_held");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset_release");

      // Ramp up from rest
      push(32, 1); push(64, 1); push(96, 1); push(100, 1);
      send(100, 1, w, d);
      wait_dc(100, "ramp_reach_100");
      check("ramp_last_busy", busy, 1);
      check("ramp_last_at_target", at_target, 0);
      @(negedge clk);
      check("ramp_done_busy", busy, 0);
      check("ramp_done_at_target", at_target, 1);

      // Reversal with brake and dead time
      push(68, 1); push(36, 1); push(4, 1); push(0, 1);
      push(0, 0); push(32, 0); push(64, 0);
      send(64, 0, w, d);
      wait_dc(0, "rev_brake_zero");
      cnt = 0;
      while (direction !== 1'b0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (cnt == 15) check("rev_ready_in_dead", tgt_ready, 0);
      end
      check("rev_dead_cycles", cnt, 30);
      wait_idle("rev_idle");
      check("rev_final_dc", motor_dc, 64);
      check("rev_final_dir", direction, 0);
      check("rev_at_target", at_target, 1);

      // Obstruction while reversing has no effect
      estop = 1'b1;
      repeat (25) @(negedge clk);
      check("estop_rev_dc", motor_dc, 64);
      check("estop_rev_dir", direction, 0);
      check("estop_rev_busy", busy, 0);
      estop = 1'b0;

      // Offer held during the dead time, accepted on the first ramp cycle
      push(32, 0); push(0, 0); push(0, 1);
      push(32, 1); push(64, 1); push(96, 1); push(128, 1);
      push(160, 1); push(192, 1); push(200, 1);
      send(50, 1, w, d);
      wait_dc(0, "stall_brake_zero");
      repeat (5) @(negedge clk);
      check("stall_ready_low", tgt_ready, 0);
      send(200, 1, w, d);
      check("stall_wait_cycles", w, 25);
      check("stall_dir_at_accept", d, 1);
      wait_idle("stall_idle");
      check("stall_final_dc", motor_dc, 200);

      // Clamping at both ends of the range
      push(232, 1); push(240, 1);
      send(240, 1, w, d);
      wait_idle("clamp_240_idle");
      push(255, 1);
      send(255, 1, w, d);
      wait_idle("clamp_255_idle");
      check("clamp_255_dc", motor_dc, 255);
      push(223, 1); push(191, 1); push(159, 1); push(127, 1);
      push(95, 1); push(63, 1); push(31, 1); push(10, 1);
      send(10, 1, w, d);
      wait_idle("clamp_10_idle");
      push(0, 1);
      send(0, 1, w, d);
      wait_idle("clamp_0_idle");
      check("clamp_0_dc", motor_dc, 0);

      // Forward obstruction mid-ramp, with a simultaneous offer that is dropped
      push(32, 1); push(64, 1); push(96, 1); push(0, 1);
      send(200, 1, w, d);
      wait_dc(96, "estop_reach_96");
      estop     = 1'b1;
      tgt_valid = 1'b1;
      tgt_dc    = 8'd150;
      tgt_dir   = 1'b1;
      check("estop_offer_ready", tgt_ready, 1);
      @(negedge clk);
      tgt_valid = 1'b0;
      check("estop_dc", motor_dc, 0);
      check("estop_busy", busy, 0);
      check("estop_target_cleared", at_target, 1);
      repeat (25) @(negedge clk);
      estop = 1'b0;
      repeat (25) @(negedge clk);
      check("estop_after_dc", motor_dc, 0);
      check("estop_after_busy", busy, 0);

      // Asynchronous reset in the middle of a ramp
      push(32, 1); push(64, 1); push(0, 1);
      send(100, 1, w, d);
      wait_dc(64, "mid_reset_reach_64");
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
